// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: one-cycle capture of decoded control and operands,
// with freeze (hold), flush (bubble) and a saturating bubble counter.
// Optional forwarding source fields are enabled by defining ID_EX_FWD_EN.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic              imm_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [3:0]        dest_in,
  input  logic [3:0]        sr_in,
`ifdef ID_EX_FWD_EN
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  input  logic              two_src_in,
  output logic [3:0]        src1_out,
  output logic [3:0]        src2_out,
  output logic              two_src_out,
`endif
  output logic [DATA_W-1:0] pc_out,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic              b_out,
  output logic              s_out,
  output logic              imm_out,
  output logic [3:0]        exe_cmd_out,
  output logic [DATA_W-1:0] val_rn_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm_24_out,
  output logic [3:0]        dest_out,
  output logic [3:0]        sr_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              b;
    logic              s;
    logic              imm;
    logic [3:0]        exe_cmd;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm_24;
    logic [3:0]        dest;
    logic [3:0]        sr;
`ifdef ID_EX_FWD_EN
    logic [3:0]        src1;
    logic [3:0]        src2;
    logic              two_src;
`endif
  } stage_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_t           stage_in_s;
  stage_t           stage_d, stage_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

  assign stage_in_s.pc            = pc_in;
  assign stage_in_s.wb_en         = wb_en_in;
  assign stage_in_s.mem_r_en      = mem_r_en_in;
  assign stage_in_s.mem_w_en      = mem_w_en_in;
  assign stage_in_s.b             = b_in;
  assign stage_in_s.s             = s_in;
  assign stage_in_s.imm           = imm_in;
  assign stage_in_s.exe_cmd       = exe_cmd_in;
  assign stage_in_s.val_rn        = val_rn_in;
  assign stage_in_s.val_rm        = val_rm_in;
  assign stage_in_s.shift_operand = shift_operand_in;
  assign stage_in_s.signed_imm_24 = signed_imm_24_in;
  assign stage_in_s.dest          = dest_in;
  assign stage_in_s.sr            = sr_in;
`ifdef ID_EX_FWD_EN
  assign stage_in_s.src1          = src1_in;
  assign stage_in_s.src2          = src2_in;
  assign stage_in_s.two_src       = two_src_in;
`endif

  // Next-state selection with priority flush > freeze > load.
  always_comb begin
    stage_d      = stage_q;
    valid_d      = valid_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      stage_d = '0;
      valid_d = 1'b0;
      if (bubble_cnt_q != CNT_MAX) begin
        bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      end else begin
        bubble_cnt_d = bubble_cnt_q;
      end
    end else if (freeze) begin
      stage_d = stage_q;
      valid_d = valid_q;
    end else begin
      stage_d = stage_in_s;
      valid_d = 1'b1;
    end
  end

  // Stage state flops, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q      <= '0;
      valid_q      <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      stage_q      <= stage_d;
      valid_q      <= valid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign pc_out            = stage_q.pc;
  assign wb_en_out         = stage_q.wb_en;
  assign mem_r_en_out      = stage_q.mem_r_en;
  assign mem_w_en_out      = stage_q.mem_w_en;
  assign b_out             = stage_q.b;
  assign s_out             = stage_q.s;
  assign imm_out           = stage_q.imm;
  assign exe_cmd_out       = stage_q.exe_cmd;
  assign val_rn_out        = stage_q.val_rn;
  assign val_rm_out        = stage_q.val_rm;
  assign shift_operand_out = stage_q.shift_operand;
  assign signed_imm_24_out = stage_q.signed_imm_24;
  assign dest_out          = stage_q.dest;
  assign sr_out            = stage_q.sr;
`ifdef ID_EX_FWD_EN
  assign src1_out          = stage_q.src1;
  assign src2_out          = stage_q.src2;
  assign two_src_out       = stage_q.two_src;
`endif
  assign valid_out         = valid_q;
  assign bubble_cnt        = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized self-checking bench for id_ex_stage_reg against a field-level model;
// counter is narrowed to 4 bits so saturation is reached quickly.
module tb_id_ex_stage_reg;

  localparam int DATA_W  = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_TOP = (1 << CNT_W) - 1;
`ifdef ID_EX_FWD_EN
  localparam int PW = 2*DATA_W + DATA_W + 6 + 4 + 12 + 24 + 4 + 4 + 9;
`else
  localparam int PW = 2*DATA_W + DATA_W + 6 + 4 + 12 + 24 + 4 + 4;
`endif

  logic              clk = 1'b0;
  logic              rst, flush, freeze;
  logic [DATA_W-1:0] pc_in, val_rn_in, val_rm_in;
  logic              wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
  logic [3:0]        exe_cmd_in, dest_in, sr_in;
  logic [11:0]       shift_operand_in;
  logic [23:0]       signed_imm_24_in;
  logic [DATA_W-1:0] pc_out, val_rn_out, val_rm_out;
  logic              wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out;
  logic [3:0]        exe_cmd_out, dest_out, sr_out;
  logic [11:0]       shift_operand_out;
  logic [23:0]       signed_imm_24_out;
  logic              valid_out;
  logic [CNT_W-1:0]  bubble_cnt;
`ifdef ID_EX_FWD_EN
  logic [3:0]        src1_in, src2_in, src1_out, src2_out;
  logic              two_src_in, two_src_out;
`endif

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] exp_v;
  logic          exp_valid;
  int            exp_cnt;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .pc_in(pc_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .b_in(b_in), .s_in(s_in), .imm_in(imm_in),
    .exe_cmd_in(exe_cmd_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .sr_in(sr_in),
`ifdef ID_EX_FWD_EN
    .src1_in(src1_in), .src2_in(src2_in), .two_src_in(two_src_in),
    .src1_out(src1_out), .src2_out(src2_out), .two_src_out(two_src_out),
`endif
    .pc_out(pc_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .b_out(b_out), .s_out(s_out), .imm_out(imm_out),
    .exe_cmd_out(exe_cmd_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
    .dest_out(dest_out), .sr_out(sr_out), .valid_out(valid_out),
    .bubble_cnt(bubble_cnt)
  );

  function automatic logic [PW-1:0] in_vec();
    return {pc_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
            exe_cmd_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in,
            dest_in, sr_in
`ifdef ID_EX_FWD_EN
            , src1_in, src2_in, two_src_in
`endif
            };
  endfunction

  function automatic logic [PW-1:0] out_vec();
    return {pc_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out,
            exe_cmd_out, val_rn_out, val_rm_out, shift_operand_out, signed_imm_24_out,
            dest_out, sr_out
`ifdef ID_EX_FWD_EN
            , src1_out, src2_out, two_src_out
`endif
            };
  endfunction

  task automatic rand_inputs();
    pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
    {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in} = 6'($urandom);
    exe_cmd_in = 4'($urandom); dest_in = 4'($urandom); sr_in = 4'($urandom);
    shift_operand_in = 12'($urandom); signed_imm_24_in = 24'($urandom);
`ifdef ID_EX_FWD_EN
    src1_in = 4'($urandom); src2_in = 4'($urandom); two_src_in = 1'($urandom);
`endif
  endtask

  // Advance one clock edge, updating the model from the rules first.
  task automatic tick();
    if (flush) begin
      exp_v = '0;
      exp_valid = 1'b0;
      if (exp_cnt < CNT_TOP) exp_cnt = exp_cnt + 1;
    end else if (!freeze) begin
      exp_v = in_vec();
      exp_valid = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_v = '0;
    exp_valid = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    flush = 1'b1; freeze = 1'b0; rand_inputs(); tick();
    flush = 1'b0; rand_inputs(); tick();
    rand_inputs();
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (out_vec() !== '0 || valid_out !== 1'b0 || bubble_cnt !== '0) begin
      errors++;
      $display("FAIL reset_async: got data=%h valid=%b cnt=%h, want all zero",
               out_vec(), valid_out, bubble_cnt);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_load();
    rand_inputs();
    flush = 1'b0; freeze = 1'b0;
    pc_in = 32'h0000_0010; val_rm_in = 32'h0000_000F; shift_operand_in = 12'h0E3;
    imm_in = 1'b0; exe_cmd_in = 4'b0001; wb_en_in = 1'b1;
    tick();
    checks++;
    if (out_vec() !== exp_v || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL load: got %h valid=%b, want %h valid=1", out_vec(), valid_out, exp_v);
    end
    checks++;
    if (pc_out !== 32'h0000_0010 || val_rm_out !== 32'h0000_000F ||
        shift_operand_out !== 12'h0E3 || exe_cmd_out !== 4'b0001 || wb_en_out !== 1'b1) begin
      errors++;
      $display("FAIL load_fields: got pc=%h rm=%h sh=%h cmd=%h wb=%b, want 10/f/0e3/1/1",
               pc_out, val_rm_out, shift_operand_out, exe_cmd_out, wb_en_out);
    end
  endtask

  task automatic test_freeze();
    logic [PW-1:0] held;
    held = exp_v;
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      tick();
      checks++;
      if (out_vec() !== held || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL freeze_hold[%0d]: got %h valid=%b, want %h valid=1",
                 i, out_vec(), valid_out, held);
      end
    end
    freeze = 1'b0;
    rand_inputs();
    tick();
    checks++;
    if (out_vec() !== exp_v || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL freeze_release: got %h, want %h", out_vec(), exp_v);
    end
  endtask

  task automatic test_flush_priority();
    freeze = 1'b1; flush = 1'b1; rand_inputs();
    tick();
    checks++;
    if (out_vec() !== '0 || valid_out !== 1'b0 || bubble_cnt !== 4'd1) begin
      errors++;
      $display("FAIL flush_over_freeze: got %h valid=%b cnt=%0d, want 0 valid=0 cnt=1",
               out_vec(), valid_out, bubble_cnt);
    end
    freeze = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      tick();
    end
    checks++;
    if (bubble_cnt !== 4'd3 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_back_to_back: got cnt=%0d valid=%b, want cnt=3 valid=0",
               bubble_cnt, valid_out);
    end
  endtask

  task automatic test_saturation();
    flush = 1'b1; freeze = 1'b0;
    for (int i = 0; i < CNT_TOP + 4; i++) begin
      rand_inputs();
      tick();
      checks++;
      if (bubble_cnt !== CNT_W'(exp_cnt)) begin
        errors++;
        $display("FAIL saturate[%0d]: got cnt=%0d, want %0d", i, bubble_cnt, exp_cnt);
      end
    end
    checks++;
    if (bubble_cnt !== 4'hF) begin
      errors++;
      $display("FAIL saturate_final: got cnt=%h, want f", bubble_cnt);
    end
    flush = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      flush  = ($urandom_range(7) == 0);
      freeze = ($urandom_range(3) == 0);
      tick();
      checks++;
      if (out_vec() !== exp_v || valid_out !== exp_valid || bubble_cnt !== CNT_W'(exp_cnt)) begin
        errors++;
        $display("FAIL random[%0d]: got %h v=%b c=%0d, want %h v=%b c=%0d",
                 i, out_vec(), valid_out, bubble_cnt, exp_v, exp_valid, exp_cnt);
      end
    end
    flush = 1'b0; freeze = 1'b0;
  endtask

  task automatic test_reset_mid_freeze();
    freeze = 1'b1; flush = 1'b0; rand_inputs();
    tick();
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (out_vec() !== '0 || valid_out !== 1'b0 || bubble_cnt !== '0) begin
      errors++;
      $display("FAIL reset_mid_freeze: got %h valid=%b cnt=%0d, want zero",
               out_vec(), valid_out, bubble_cnt);
    end
    #1 rst = 1'b0;
    tick();
    checks++;
    if (out_vec() !== '0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_freeze: got %h valid=%b, want zero", out_vec(), valid_out);
    end
    freeze = 1'b0; rand_inputs();
    tick();
    checks++;
    if (out_vec() !== exp_v || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_load: got %h, want %h", out_vec(), exp_v);
    end
  endtask

`ifdef ID_EX_FWD_EN
  task automatic test_fwd();
    flush = 1'b0; freeze = 1'b0; rand_inputs();
    src1_in = 4'd3; src2_in = 4'd7; two_src_in = 1'b1;
    tick();
    checks++;
    if (src1_out !== 4'd3 || src2_out !== 4'd7 || two_src_out !== 1'b1) begin
      errors++;
      $display("FAIL fwd_load: got %0d/%0d/%b, want 3/7/1", src1_out, src2_out, two_src_out);
    end
    flush = 1'b1; rand_inputs();
    tick();
    checks++;
    if (src1_out !== 4'd0 || src2_out !== 4'd0 || two_src_out !== 1'b0) begin
      errors++;
      $display("FAIL fwd_flush: got %0d/%0d/%b, want 0/0/0", src1_out, src2_out, two_src_out);
    end
    flush = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; flush = 1'b0; freeze = 1'b0;
    rand_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_load();
    test_freeze();
    test_flush_priority();
    test_saturation();
    test_random();
    test_reset_mid_freeze();
`ifdef ID_EX_FWD_EN
    test_fwd();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
